arb_req_frontend: RTL

- Upstream companion of the round-robin arbiter.
- Buffers requests from VECTOR_IN source ports in per-port FIFOs and drives the arbiter's request_vector.
- Consumes the arbiter's registered one-hot grant, which arrives 1 cycle after the request.
- Forwards the granted entry, tagged with its port index, through a 2-entry output buffer with valid/ready handshake.

---
 rtl/arb_req_frontend.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/arb_req_frontend.sv
// Request front-end for the round-robin arbiter: per-port input FIFOs, request
// generation, grant consumption and a 2-entry tagged output buffer.
module arb_req_frontend #(
    parameter int VECTOR_IN  = 8,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [VECTOR_IN-1:0]          in_valid,
    input  logic [VECTOR_IN*DATA_W-1:0]   in_data,
    output logic [VECTOR_IN-1:0]          in_ready,
    output logic [VECTOR_IN-1:0]          request_vector,
    input  logic [VECTOR_IN-1:0]          grant,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data,
    output logic [$clog2(VECTOR_IN)-1:0]  out_port,
    input  logic                          out_ready,
    output logic                          grant_err
);
    localparam int PW = $clog2(VECTOR_IN);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0]    mem    [VECTOR_IN][FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr [VECTOR_IN];
    logic [AW-1:0]        rd_ptr [VECTOR_IN];
    logic [CW-1:0]        cnt    [VECTOR_IN];

    logic [VECTOR_IN-1:0] push;
    logic [VECTOR_IN-1:0] pop;
    logic [VECTOR_IN-1:0] empty;
    logic                 grant_multi;
    logic                 grant_illegal;
    logic                 pop_any;
    logic [PW-1:0]        grant_idx;
    logic [DATA_W-1:0]    head_data;

    logic [DATA_W-1:0]    ob_data [2];
    logic [PW-1:0]        ob_port [2];
    logic                 ob_wr;
    logic                 ob_rd;
    logic [1:0]           ob_cnt;
    logic                 ob_pop;
    logic [2:0]           ob_need;
    logic                 space_ok;

    always_comb begin
        empty    = '0;
        in_ready = '0;
        push     = '0;
        for (int unsigned i = 0; i < VECTOR_IN; i++) begin
            empty[i]    = (cnt[i] == '0);
            in_ready[i] = (cnt[i] < CW'(FIFO_DEPTH));
            push[i]     = in_valid[i] & in_ready[i];
        end
    end

    assign grant_multi   = (grant & (grant - VECTOR_IN'(1))) != '0;
    assign grant_illegal = grant_multi | (|(grant & empty));
    assign pop           = grant_illegal ? '0 : grant;
    assign pop_any       = |pop;

    // Explicit one-hot to index encoder for the output tag and head select.
    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < VECTOR_IN; i++) begin
            if (grant[i]) begin
                grant_idx = PW'(i);
            end
        end
    end

    assign head_data = mem[grant_idx][rd_ptr[grant_idx]];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < VECTOR_IN; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < VECTOR_IN; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < VECTOR_IN; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + AW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + AW'(1);
                end
                if (push[i] && !pop[i]) begin
                    cnt[i] <= cnt[i] + CW'(1);
                end else if (pop[i] && !push[i]) begin
                    cnt[i] <= cnt[i] - CW'(1);
                end
            end
        end
    end

    assign out_valid = (ob_cnt != 2'd0);
    assign out_data  = ob_data[ob_rd];
    assign out_port  = ob_port[ob_rd];
    assign ob_pop    = out_valid & out_ready;

    // The slot reservation credits this cycle's downstream pop, so an
    // unstalled stream keeps requesting every cycle without overflow risk.
    assign ob_need  = {1'b0, ob_cnt} - {2'b00, ob_pop} + {2'b00, |grant};
    assign space_ok = (ob_need < 3'd2);

    always_comb begin
        request_vector = '0;
        for (int unsigned i = 0; i < VECTOR_IN; i++) begin
            request_vector[i] = space_ok && (cnt[i] > CW'(grant[i]));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ob_data[0] <= '0;
            ob_data[1] <= '0;
            ob_port[0] <= '0;
            ob_port[1] <= '0;
            ob_wr      <= 1'b0;
            ob_rd      <= 1'b0;
            ob_cnt     <= 2'd0;
            grant_err  <= 1'b0;
        end else begin
            if (pop_any) begin
                ob_data[ob_wr] <= head_data;
                ob_port[ob_wr] <= grant_idx;
                ob_wr          <= ~ob_wr;
            end
            if (ob_pop) begin
                ob_rd <= ~ob_rd;
            end
            case ({pop_any, ob_pop})
                2'b10:   ob_cnt <= ob_cnt + 2'd1;
                2'b01:   ob_cnt <= ob_cnt - 2'd1;
                default: ob_cnt <= ob_cnt;
            endcase
            if (grant_illegal) begin
                grant_err <= 1'b1;
            end
        end
    end

endmodule
